// File: rtl/complement_pkg.sv
// Shared types for the bit-serial two's-complement sequencer.
package complement_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_t;

    localparam int CMP_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/complement_bit_cell.sv
// One slice of the two's-complement chain: invert every bit above the lowest set bit.
module complement_bit_cell (
    input  logic a,
    input  logic flag,
    output logic w,
    output logic nflag
);

    assign w     = a ^ flag;
    assign nflag = a | flag;

endmodule

// File: rtl/serial_complement_ctrl.sv
// Bit-serial two's-complement negator: one operand per handshake, one bit per clock LSB-first,
// result presented with a valid/ready handshake.
module serial_complement_ctrl
    import complement_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    cmp_state_t       state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic             flag;
    logic             w;
    logic             nflag;
    logic             accept;
    logic             last;

    complement_bit_cell u_cell (
        .a     (sreg[0]),
        .flag  (flag),
        .w     (w),
        .nflag (nflag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(WIDTH-1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = result;

    // The flag is cleared on every accept so no carry state leaks between operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            result <= '0;
            opnd   <= '0;
            cnt    <= '0;
            flag   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sreg <= in_data;
            opnd <= in_data;
            flag <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            flag   <= nflag;
            result <= {w, result[WIDTH-1:1]};
            sreg   <= sreg >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                zero <= (opnd == '0);
                ovf  <= (opnd == MOST_NEG);
            end
        end
    end

endmodule

// File: tb/tb_serial_complement_ctrl.sv
// Scoreboard bench for serial_complement_ctrl: stimulus pushes expected results, a monitor pops them.
module tb_serial_complement_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         zero;
    logic         ovf;
    logic         busy;

    logic rand_ready = 1'b0;
    logic rdy_ctl = 1'b1;
    logic rnd_bit = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   pushed = 0;
    int   popped = 0;
    exp_t exp_q[$];

    logic         prev_vld = 1'b0;
    logic         prev_hs = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_zero = 1'b0;
    logic         prev_ovf = 1'b0;

    assign out_ready = rand_ready ? rnd_bit : rdy_ctl;

    serial_complement_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    function automatic exp_t model(input int a);
        exp_t e;
        e.data = W'((256 - a) % 256);
        e.zero = (a == 0);
        e.ovf  = (a == 128);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input int a);
        int n;
        n = 0;
        in_data  = W'(a);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
        end else begin
            acc_cyc = cyc;
            exp_q.push_back(model(a));
            pushed++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: latency on rising out_valid, stability under backpressure, scoreboard on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_vld)
                check("latency", cyc - acc_cyc - 1, W);
            if (out_valid && prev_vld && !prev_hs)
                check("hold_stable", {out_data, zero, ovf}, {prev_data, prev_zero, prev_ovf});
            if (out_valid && out_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", {out_data, zero, ovf}, {e.data, e.zero, e.ovf});
                end
            end
        end
        prev_vld  = out_valid && !rst;
        prev_hs   = out_valid && out_ready;
        prev_data = out_data;
        prev_zero = zero;
        prev_ovf  = ovf;
    end

    initial begin
        int n;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_outputs", {out_data, zero, ovf}, 0);
        @(posedge clk);
        #1;

        // Directed operands, consumer always ready.
        rdy_ctl = 1'b1;
        send(8'hFF);
        send(8'h00);
        send(8'h01);
        send(8'h80);
        send(8'h7F);
        idle(12);

        // Backpressure with an ignored in_valid pulse.
        rdy_ctl = 1'b0;
        send(8'h3C);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k == 1);
            in_data  = 8'h11;
            @(negedge clk);
            check("bp_data", out_data, 8'hC4);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_ctl  = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);
        @(posedge clk);
        #1;

        // Reset in the 3rd SHIFT cycle discards the operand.
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        @(posedge clk);
        #1;
        send(8'h5A);
        idle(12);

        // Full sweep with random gaps on both sides.
        rand_ready = 1'b1;
        for (int a = 0; a < 256; a++) begin
            idle($urandom_range(0, 3));
            send(a);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        rand_ready = 1'b0;
        idle(20);
        check("queue_drained", exp_q.size(), 0);
        check("result_count", popped, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
